armleocpu_load_aligner: RTL and testbench

Parametrised, sequential successor to the combinational load data generator. Takes a load request (in-word byte offset and funct3 type) and issues one or two aligned bus beats. It merges and right-aligns the returned data, applies zero- or sign-extension, and presents the result to the writeback stage over a valid/ready handshake. XLEN=64 adds doubleword and word-unsigned loads.

---
 rtl/armleocpu_load_pkg.sv | 44 ++++
 rtl/armleocpu_load_extend.sv | 28 ++
 rtl/armleocpu_load_aligner.sv | 211 +++++++++++++++++++++
 tb/tb_armleocpu_load_aligner.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_load_pkg.sv
// Shared load-type encodings, FSM state encoding and size/legality helpers
// for the load aligner and its extension unit.
package armleocpu_load_pkg;

  localparam logic [2:0] LOAD_BYTE   = 3'b000;
  localparam logic [2:0] LOAD_HALF   = 3'b001;
  localparam logic [2:0] LOAD_WORD   = 3'b010;
  localparam logic [2:0] LOAD_DOUBLE = 3'b011;
  localparam logic [2:0] LOAD_BYTE_U = 3'b100;
  localparam logic [2:0] LOAD_HALF_U = 3'b101;
  localparam logic [2:0] LOAD_WORD_U = 3'b110;

  typedef enum logic [2:0] {
    STATE_IDLE   = 3'd0,
    STATE_ISSUE0 = 3'd1,
    STATE_WAIT0  = 3'd2,
    STATE_ISSUE1 = 3'd3,
    STATE_WAIT1  = 3'd4,
    STATE_RESP   = 3'd5
  } state_t;

  function automatic logic [3:0] load_size(input logic [2:0] load_type);
    logic [3:0] size;
    case (load_type[1:0])
      2'b00:   size = 4'd1;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd4;
      default: size = 4'd8;
    endcase
    return size;
  endfunction

  // DOUBLE and WORD_U only exist on a 64-bit datapath.
  function automatic logic is_legal(input logic [2:0] load_type, input int xlen);
    logic legal;
    case (load_type)
      LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_U, LOAD_HALF_U: legal = 1'b1;
      LOAD_DOUBLE, LOAD_WORD_U: legal = (xlen == 64);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/armleocpu_load_extend.sv
// Combinational zero/sign extension of the right-aligned load data
// according to the RISC-V funct3 load type.
module armleocpu_load_extend
  import armleocpu_load_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [2:0]      i_type,
  output logic [XLEN-1:0] o_data
);

  // Select the extension width and signedness from the load type.
  always_comb begin
    o_data = '0;
    case (i_type)
      LOAD_BYTE:   o_data = XLEN'($signed(i_data[7:0]));
      LOAD_HALF:   o_data = XLEN'($signed(i_data[15:0]));
      LOAD_WORD:   o_data = XLEN'($signed(i_data[31:0]));
      LOAD_DOUBLE: o_data = i_data;
      LOAD_BYTE_U: o_data = XLEN'(i_data[7:0]);
      LOAD_HALF_U: o_data = XLEN'(i_data[15:0]);
      LOAD_WORD_U: o_data = XLEN'(i_data[31:0]);
      default:     o_data = '0;
    endcase
  end

endmodule

// File: rtl/armleocpu_load_aligner.sv
// Sequential load aligner: issues one or two aligned bus beats, merges, aligns and
// extends the data. Optional macro ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN enables misaligned loads.
module armleocpu_load_aligner
  import armleocpu_load_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OFFW-1:0] req_offset,
  input  logic [2:0]      req_type,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_req_second,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rsp_data,
  input  logic            bus_rsp_error,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_missaligned,
  output logic            rsp_unknowntype,
  output logic            rsp_accessfault
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("armleocpu_load_aligner: XLEN must be 32 or 64");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OFFW-1:0] r_offset;
  logic [2:0]      r_type;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_unknowntype;
  logic            r_accessfault;
  logic [3:0]      w_req_size;
  logic            w_req_unknown;
  logic            w_req_reject;
  logic [XLEN-1:0] w_merge_lo;
  logic [XLEN-1:0] w_merge_hi;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_extended;

  assign w_req_size    = load_size(req_type);
  assign w_req_unknown = !is_legal(req_type, XLEN);

`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
  logic            r_crossing;
  logic [XLEN-1:0] r_beat0;
  logic            w_req_cross;

  assign w_req_cross  = (int'(req_offset) + int'(w_req_size)) > (XLEN/8);
  assign w_req_reject = w_req_unknown;
  // The second beat supplies the upper half of the merge window.
  assign w_merge_lo   = (r_state == STATE_WAIT1) ? r_beat0 : bus_rsp_data;
  assign w_merge_hi   = (r_state == STATE_WAIT1) ? bus_rsp_data : '0;
  assign rsp_missaligned = 1'b0;
`else
  logic r_missaligned;
  logic w_req_mis;

  assign w_req_mis    = (req_offset & OFFW'(w_req_size - 4'd1)) != '0;
  assign w_req_reject = w_req_unknown || w_req_mis;
  assign w_merge_lo   = bus_rsp_data;
  assign w_merge_hi   = '0;
  assign rsp_missaligned = r_missaligned;
`endif

  assign w_shifted = XLEN'({w_merge_hi, w_merge_lo} >> {r_offset, 3'b000});

  armleocpu_load_extend #(.XLEN(XLEN)) u_extend (
    .i_data (w_shifted),
    .i_type (r_type),
    .o_data (w_extended)
  );

  assign req_ready       = (r_state == STATE_IDLE);
  assign bus_req_valid   = (r_state == STATE_ISSUE0) || (r_state == STATE_ISSUE1);
  assign bus_req_second  = (r_state == STATE_ISSUE1);
  assign rsp_valid       = (r_state == STATE_RESP);
  assign rsp_data        = r_rsp_data;
  assign rsp_unknowntype = r_unknowntype;
  assign rsp_accessfault = r_accessfault;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STATE_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STATE_IDLE: begin
        if (req_valid) begin
          if (w_req_reject) w_state_nxt = STATE_RESP;
          else              w_state_nxt = STATE_ISSUE0;
        end else begin
          w_state_nxt = STATE_IDLE;
        end
      end
      STATE_ISSUE0: begin
        if (bus_req_ready) w_state_nxt = STATE_WAIT0;
        else               w_state_nxt = STATE_ISSUE0;
      end
      STATE_WAIT0: begin
        if (bus_rsp_valid) begin
`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
          if (!bus_rsp_error && r_crossing) w_state_nxt = STATE_ISSUE1;
          else                              w_state_nxt = STATE_RESP;
`else
          w_state_nxt = STATE_RESP;
`endif
        end else begin
          w_state_nxt = STATE_WAIT0;
        end
      end
`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
      STATE_ISSUE1: begin
        if (bus_req_ready) w_state_nxt = STATE_WAIT1;
        else               w_state_nxt = STATE_ISSUE1;
      end
      STATE_WAIT1: begin
        if (bus_rsp_valid) w_state_nxt = STATE_RESP;
        else               w_state_nxt = STATE_WAIT1;
      end
`endif
      STATE_RESP: begin
        if (rsp_ready) w_state_nxt = STATE_IDLE;
        else           w_state_nxt = STATE_RESP;
      end
      default: w_state_nxt = STATE_IDLE;
    endcase
  end

  // Request latch, beat capture and registered result; cleared after handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset      <= '0;
      r_type        <= 3'b000;
      r_rsp_data    <= '0;
      r_unknowntype <= 1'b0;
      r_accessfault <= 1'b0;
`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
      r_crossing    <= 1'b0;
      r_beat0       <= '0;
`else
      r_missaligned <= 1'b0;
`endif
    end else begin
      case (r_state)
        STATE_IDLE: begin
          if (req_valid) begin
            r_offset      <= req_offset;
            r_type        <= req_type;
            r_rsp_data    <= '0;
            r_unknowntype <= w_req_unknown;
            r_accessfault <= 1'b0;
`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
            r_crossing    <= w_req_cross;
`else
            r_missaligned <= !w_req_unknown && w_req_mis;
`endif
          end
        end
        STATE_WAIT0: begin
          if (bus_rsp_valid) begin
            r_accessfault <= bus_rsp_error;
`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
            r_beat0 <= bus_rsp_data;
            if (bus_rsp_error || !r_crossing) begin
              r_rsp_data <= bus_rsp_error ? '0 : w_extended;
            end
`else
            r_rsp_data <= bus_rsp_error ? '0 : w_extended;
`endif
          end
        end
`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
        STATE_WAIT1: begin
          if (bus_rsp_valid) begin
            r_accessfault <= r_accessfault | bus_rsp_error;
            r_rsp_data    <= (r_accessfault | bus_rsp_error) ? '0 : w_extended;
          end
        end
`endif
        STATE_RESP: begin
          if (rsp_ready) begin
            r_rsp_data    <= '0;
            r_unknowntype <= 1'b0;
            r_accessfault <= 1'b0;
`ifndef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
            r_missaligned <= 1'b0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_load_aligner.sv
// Directed bench for armleocpu_load_aligner: one XLEN=32 and one XLEN=64 instance,
// zero-wait and stalled bus stimulus with hand-computed expectations.
module tb_armleocpu_load_aligner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_bus_req_valid, a_bus_req_ready, a_bus_req_second;
  logic [1:0]  a_req_offset;
  logic [2:0]  a_req_type;
  logic        a_bus_rsp_valid, a_bus_rsp_error, a_rsp_valid, a_rsp_ready;
  logic [31:0] a_bus_rsp_data, a_rsp_data;
  logic        a_rsp_mis, a_rsp_unk, a_rsp_af;

  logic        b_req_valid, b_req_ready, b_bus_req_valid, b_bus_req_ready, b_bus_req_second;
  logic [2:0]  b_req_offset;
  logic [2:0]  b_req_type;
  logic        b_bus_rsp_valid, b_bus_rsp_error, b_rsp_valid, b_rsp_ready;
  logic [63:0] b_bus_rsp_data, b_rsp_data;
  logic        b_rsp_mis, b_rsp_unk, b_rsp_af;

  int total = 0;
  int bad   = 0;

  armleocpu_load_aligner #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_offset(a_req_offset), .req_type(a_req_type),
    .bus_req_valid(a_bus_req_valid), .bus_req_ready(a_bus_req_ready),
    .bus_req_second(a_bus_req_second),
    .bus_rsp_valid(a_bus_rsp_valid), .bus_rsp_data(a_bus_rsp_data),
    .bus_rsp_error(a_bus_rsp_error),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_missaligned(a_rsp_mis), .rsp_unknowntype(a_rsp_unk),
    .rsp_accessfault(a_rsp_af)
  );

  armleocpu_load_aligner #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_offset(b_req_offset), .req_type(b_req_type),
    .bus_req_valid(b_bus_req_valid), .bus_req_ready(b_bus_req_ready),
    .bus_req_second(b_bus_req_second),
    .bus_rsp_valid(b_bus_rsp_valid), .bus_rsp_data(b_bus_rsp_data),
    .bus_rsp_error(b_bus_rsp_error),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_missaligned(b_rsp_mis), .rsp_unknowntype(b_rsp_unk),
    .rsp_accessfault(b_rsp_af)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic release32;
    a_rsp_ready = 1'b1;
    tick;
    a_rsp_ready = 1'b0;
  endtask

  task automatic release64;
    b_rsp_ready = 1'b1;
    tick;
    b_rsp_ready = 1'b0;
  endtask

  // Aligned single-beat load on the 64-bit instance, left in RESP.
  task automatic load64(input string tag, input logic [2:0] off, input logic [2:0] typ,
                        input logic [63:0] data);
    b_req_valid = 1'b1; b_req_offset = off; b_req_type = typ; b_bus_req_ready = 1'b1;
    tick;
    b_req_valid = 1'b0;
    chk1({tag, "_issue"}, b_bus_req_valid, 1'b1);
    tick;
    b_bus_rsp_valid = 1'b1; b_bus_rsp_data = data;
    tick;
    b_bus_rsp_valid = 1'b0;
    chk1({tag, "_valid"}, b_rsp_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_offset = 2'd0; a_req_type = 3'b000; a_bus_req_ready = 1'b0;
    a_bus_rsp_valid = 1'b0; a_bus_rsp_data = 32'h0; a_bus_rsp_error = 1'b0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_offset = 3'd0; b_req_type = 3'b000; b_bus_req_ready = 1'b0;
    b_bus_rsp_valid = 1'b0; b_bus_rsp_data = 64'h0; b_bus_rsp_error = 1'b0; b_rsp_ready = 1'b0;
    tick;
    tick;

    chk1("rst_req_ready", a_req_ready, 1'b1);
    chk1("rst_bus_req_valid", a_bus_req_valid, 1'b0);
    chk1("rst_rsp_valid", a_rsp_valid, 1'b0);
    chk32("rst_rsp_data", a_rsp_data, 32'h0);
    chk1("rst_flags", a_rsp_mis | a_rsp_unk | a_rsp_af, 1'b0);
    chk1("rst64_req_ready", b_req_ready, 1'b1);
    chk64("rst64_rsp_data", b_rsp_data, 64'h0);
    rst = 1'b0;
    tick;

    // Signed byte at offset 3, zero-wait bus, rsp_valid three cycles after accept
    a_bus_req_ready = 1'b1;
    a_req_valid = 1'b1; a_req_offset = 2'd3; a_req_type = 3'b000;
    tick;
    a_req_valid = 1'b0;
    chk1("t1_issue_valid", a_bus_req_valid, 1'b1);
    chk1("t1_issue_second", a_bus_req_second, 1'b0);
    chk1("t1_busy", a_req_ready, 1'b0);
    tick;
    chk1("t1_wait_no_bus", a_bus_req_valid, 1'b0);
    chk1("t1_wait_no_rsp", a_rsp_valid, 1'b0);
    a_bus_rsp_valid = 1'b1; a_bus_rsp_data = 32'h80FF_0000;
    tick;
    a_bus_rsp_valid = 1'b0;
    chk1("t1_rsp_valid", a_rsp_valid, 1'b1);
    chk32("t1_rsp_data", a_rsp_data, 32'hFFFF_FF80);
    chk1("t1_no_fault", a_rsp_af, 1'b0);
    chk1("t1_resp_not_ready", a_req_ready, 1'b0);
    release32;
    chk1("t1_back_idle", a_req_ready, 1'b1);
    chk1("t1_rsp_dropped", a_rsp_valid, 1'b0);

`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
    // Split word at offset 2: two beats, merged upper half of beat0 with lower half of beat1
    a_req_valid = 1'b1; a_req_offset = 2'd2; a_req_type = 3'b010;
    tick;
    a_req_valid = 1'b0;
    chk1("t2_beat0_valid", a_bus_req_valid, 1'b1);
    chk1("t2_beat0_second", a_bus_req_second, 1'b0);
    tick;
    a_bus_rsp_valid = 1'b1; a_bus_rsp_data = 32'hAABB_CCDD;
    tick;
    a_bus_rsp_valid = 1'b0;
    chk1("t2_beat1_valid", a_bus_req_valid, 1'b1);
    chk1("t2_beat1_second", a_bus_req_second, 1'b1);
    tick;
    a_bus_rsp_valid = 1'b1; a_bus_rsp_data = 32'h1122_3344;
    tick;
    a_bus_rsp_valid = 1'b0;
    chk1("t2_rsp_valid", a_rsp_valid, 1'b1);
    chk32("t2_rsp_data", a_rsp_data, 32'h3344_AABB);
    chk1("t2_mis_tied", a_rsp_mis, 1'b0);
    release32;
`else
    // Misaligned half at offset 1 is rejected without bus traffic
    a_req_valid = 1'b1; a_req_offset = 2'd1; a_req_type = 3'b001;
    tick;
    a_req_valid = 1'b0;
    chk1("t3_no_bus", a_bus_req_valid, 1'b0);
    chk1("t3_rsp_valid", a_rsp_valid, 1'b1);
    chk1("t3_missaligned", a_rsp_mis, 1'b1);
    chk1("t3_not_unknown", a_rsp_unk, 1'b0);
    chk32("t3_rsp_data", a_rsp_data, 32'h0);
    release32;
    chk1("t3_mis_cleared", a_rsp_mis, 1'b0);
`endif

    // 64-bit-only types on the 32-bit instance are unknown
    a_req_valid = 1'b1; a_req_offset = 2'd0; a_req_type = 3'b011;
    tick;
    a_req_valid = 1'b0;
    chk1("t4_32_double_unknown", a_rsp_unk, 1'b1);
    chk1("t4_32_double_no_bus", a_bus_req_valid, 1'b0);
    release32;

    load64("t4_wordu", 3'd4, 3'b110, 64'hF000_0001_1234_5678);
    chk64("t4_wordu_data", b_rsp_data, 64'h0000_0000_F000_0001);
    release64;
    load64("t4_half", 3'd6, 3'b001, 64'h8001_0000_0000_0000);
    chk64("t4_half_data", b_rsp_data, 64'hFFFF_FFFF_FFFF_8001);
    release64;
    load64("t4_double", 3'd0, 3'b011, 64'h8123_4567_89AB_CDEF);
    chk64("t4_double_data", b_rsp_data, 64'h8123_4567_89AB_CDEF);
    release64;
    b_req_valid = 1'b1; b_req_offset = 3'd0; b_req_type = 3'b111;
    tick;
    b_req_valid = 1'b0;
    chk1("t4_111_unknown", b_rsp_unk, 1'b1);
    chk1("t4_111_no_bus", b_bus_req_valid, 1'b0);
    chk64("t4_111_data", b_rsp_data, 64'h0);
    release64;

    // Faulting beat with a stalled bus request, then a held response
    a_bus_req_ready = 1'b0;
`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
    a_req_valid = 1'b1; a_req_offset = 2'd2; a_req_type = 3'b010;
`else
    a_req_valid = 1'b1; a_req_offset = 2'd0; a_req_type = 3'b010;
`endif
    tick;
    a_req_valid = 1'b0;
    chk1("t5_issue", a_bus_req_valid, 1'b1);
    tick;
    chk1("t5_issue_held", a_bus_req_valid, 1'b1);
    a_bus_req_ready = 1'b1;
    tick;
    a_bus_rsp_valid = 1'b1; a_bus_rsp_error = 1'b1; a_bus_rsp_data = 32'h1234_5678;
    tick;
    a_bus_rsp_valid = 1'b0; a_bus_rsp_error = 1'b0;
    chk1("t5_no_second_beat", a_bus_req_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("t5_hold_valid", a_rsp_valid, 1'b1);
      chk1("t5_hold_fault", a_rsp_af, 1'b1);
      chk32("t5_hold_data", a_rsp_data, 32'h0);
      tick;
    end
    release32;
    chk1("t5_released", a_req_ready, 1'b1);

    // A response pulse while idle must be ignored
    a_bus_rsp_valid = 1'b1; a_bus_rsp_data = 32'hDEAD_BEEF;
    tick;
    a_bus_rsp_valid = 1'b0;
    chk1("t6_idle_rsp_ignored", a_rsp_valid, 1'b0);

    // Reset while waiting for a beat; the late response is dropped
`ifdef ARMLEOCPU_LOAD_ALIGNER_MISALIGNED_EN
    a_req_valid = 1'b1; a_req_offset = 2'd2; a_req_type = 3'b010;
    tick;
    a_req_valid = 1'b0;
    tick;
    a_bus_rsp_valid = 1'b1; a_bus_rsp_data = 32'hAABB_CCDD;
    tick;
    a_bus_rsp_valid = 1'b0;
    tick;
    chk1("t6_in_wait1", a_bus_req_valid, 1'b0);
`else
    a_req_valid = 1'b1; a_req_offset = 2'd0; a_req_type = 3'b000;
    tick;
    a_req_valid = 1'b0;
    tick;
    chk1("t6_in_wait0", a_bus_req_valid, 1'b0);
`endif
    chk1("t6_busy", a_req_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk1("t6_async_idle", a_req_ready, 1'b1);
    a_bus_rsp_valid = 1'b1; a_bus_rsp_data = 32'h0102_0304;
    tick;
    rst = 1'b0;
    tick;
    a_bus_rsp_valid = 1'b0;
    chk1("t6_after_ready", a_req_ready, 1'b1);
    chk1("t6_no_rsp", a_rsp_valid, 1'b0);
    tick;
    chk1("t6_still_no_rsp", a_rsp_valid, 1'b0);
    chk32("t6_data_clear", a_rsp_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
